// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: system clock rate, standard tick divisors and
// the default timebase counter width.
package stopwatch_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DIV_2KHZ    = 25_000;
    localparam int DIV_1KHZ    = 50_000;
    localparam int DIV_DISPLAY = 51_600;
    localparam int CNT_W_DEF   = 26;

    // cfg_ch is 3 bits wide, so builds with fewer than 8 channels
    // must reject the unused channel numbers.
    function automatic logic cfg_ch_valid(input logic [2:0] ch, input int num_ch);
        return int'(ch) < num_ch;
    endfunction

endpackage

// File: rtl/tick_generator_if.sv
// Control/status bundle of the multi-channel tick generator: run/clear,
// divisor configuration bus and the per-channel tick/square outputs.
interface tick_generator_if
    import stopwatch_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              run;
    logic              sync_clear;
    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_pend;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;

    modport master (
        output run, sync_clear, cfg_wr, cfg_ch, cfg_div,
        input  cfg_err, cfg_pend, tick, sq
    );

    modport slave (
        input  run, sync_clear, cfg_wr, cfg_ch, cfg_div,
        output cfg_err, cfg_pend, tick, sq
    );

endinterface

// File: rtl/tick_generator_channel.sv
// One timebase channel: wrapping counter, shadowed divisor that is applied
// on the next wrap, registered tick pulse and 50 % square wave.
module tick_channel
    import stopwatch_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_2KHZ)
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync_clear,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap;

    assign wrap = (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (sync_clear) begin
            // Clear re-phases the channel and adopts the newest divisor at once.
            cnt_d  = '0;
            sq_d   = 1'b0;
            pend_d = 1'b0;
            if (wr_en) begin
                div_d = wr_div;
                shd_d = wr_div;
            end else if (pend_q) begin
                div_d = shd_q;
            end
        end else begin
            if (run) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                    if (pend_q) begin
                        div_d  = shd_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A write landing on a wrap edge waits for the following wrap.
            if (wr_en) begin
                shd_d  = wr_div;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            shd_q  <= DIV_RST;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign pend = pend_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel stopwatch timebase: decodes divisor writes to NUM_CH
// independent tick channels and flags rejected writes on cfg_err.
module tick_generator
    import stopwatch_pkg::*;
#(
    parameter int                      NUM_CH   = 2,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_1KHZ), CNT_W'(DIV_2KHZ)}
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    tick_generator_if.slave  bus
);

    logic              div_nz;
    logic              ch_ok;
    logic              cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] sq_w;
    logic [NUM_CH-1:0] pend_w;

    assign div_nz = |bus.cfg_div;
    assign ch_ok  = cfg_ch_valid(bus.cfg_ch, NUM_CH);

    always_comb begin
        cfg_err_d = bus.cfg_wr && !(div_nz && ch_ok);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_en[gi] = bus.cfg_wr && div_nz && (int'(bus.cfg_ch) == gi);

            tick_channel #(
                .CNT_W   (CNT_W),
                .DIV_RST (DIV_INIT[gi*CNT_W +: CNT_W])
            ) u_ch (
                .clk_50MHz  (clk_50MHz),
                .rst_n      (rst_n),
                .run        (bus.run),
                .sync_clear (bus.sync_clear),
                .wr_en      (wr_en[gi]),
                .wr_div     (bus.cfg_div),
                .tick       (tick_w[gi]),
                .sq         (sq_w[gi]),
                .pend       (pend_w[gi])
            );
        end
    endgenerate

    assign bus.tick     = tick_w;
    assign bus.sq       = sq_w;
    assign bus.cfg_pend = pend_w;
    assign bus.cfg_err  = cfg_err_q;

endmodule

// File: doc/tick_generator.md
# tick_generator

Parametrised multi-channel timebase for the stopwatch, successor to the fixed two-output clock divider. It derives NUM_CH independent tick streams from clk_50MHz, each with a runtime-programmable period. Each channel produces a single-cycle clock-enable pulse plus a 50 % duty square wave. Downstream logic (millisecond counter, display multiplexer, button debouncer) stays on clk_50MHz and qualifies on tick[i] instead of using derived clocks.

## Interface
- NUM_CH, 2: number of channels, 1..8.
- CNT_W, 26: divisor/counter width; covers periods up to 67,108,863 cycles (~1.34 s).
- DIV_INIT, {25_000, 50_000}: packed NUM_CH×CNT_W reset divisors; channel i at bits [i*CNT_W +: CNT_W]. Default gives ch0 2 kHz, ch1 1 kHz.

- clk_50MHz  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  1 = counters advance; 0 = all channels frozen
- sync_clear  in  1  synchronous restart of all channels (phase alignment)
- cfg_wr  in  1  one-cycle divisor write strobe
- cfg_ch  in  3  target channel of cfg_wr
- cfg_div  in  CNT_W  new period in clk_50MHz cycles
- cfg_err  out  1  one-cycle pulse: cfg_wr rejected
- cfg_pend  out  NUM_CH  per-channel: written divisor not yet applied
- tick  out  NUM_CH  one-cycle enable pulse, period = divisor
- sq  out  NUM_CH  square wave, toggles on each tick, period = 2×divisor

## Operation
- Per channel: active divisor div, shadow divisor shd, pending flag, counter cnt (0..div-1), registered tick, registered sq.
- Reset values: cnt=0, div=shd=DIV_INIT slice, pend=0, tick=0, sq=0, cfg_err=0.
- run=1: cnt increments each cycle; when cnt==div-1, cnt wraps to 0, tick=1 next cycle, sq toggles with tick. Otherwise tick=0.
- run=0: cnt, sq and pend hold; tick forced 0. Resuming continues from the held count; no extra tick.
- Divisor write: cfg_wr with cfg_ch<NUM_CH and cfg_div≥1 loads shd and sets pend. On the channel's next wrap, div←shd and pend clears. The current period always completes with the old divisor.
- A second write while pend=1 overwrites shd. Last write wins.
- Rejected writes (cfg_div==0 or cfg_ch≥NUM_CH): no state change; cfg_err=1 the following cycle.
- div=1: tick permanently high while run=1; sq toggles every cycle.
- sync_clear (priority over run): all cnt←0, sq←0, tick←0. Any pending shd is applied immediately and pend clears.
- sync_clear with cfg_wr in the same cycle: the written value becomes div directly, pend stays 0.
- Async reset mid-period: all state returns to reset values immediately. No tick is generated on release.

## Timing
- Cycle 0 is the first rising edge with rst_n=1 and run=1. tick[i] is high during the cycle after edge div-1, i.e. it first asserts after exactly div edges, then every div cycles.
- Latency: tick is registered, 1 cycle after the wrap; sq changes on the same edge as tick rises.
- cfg_pend rises 1 cycle after cfg_wr and falls on the same edge the wrap loads div. The first period with the new divisor starts at that wrap.
- sync_clear: tick low on the next cycle. First post-clear tick comes div cycles after the edge that samples sync_clear deasserted. All channels with equal div are phase-aligned.
- Throughput: one cfg_wr per cycle is accepted, with no backpressure.

## Structure
- Shared package stopwatch_pkg: CLK_HZ=50_000_000, DIV_2KHZ=25_000, DIV_1KHZ=50_000, DIV_DISPLAY=51_600, CNT_W default.
- Sub-module tick_channel (one counter, shadow register, pend, tick, sq). The top instantiates NUM_CH copies via generate and holds the cfg_ch decode and cfg_err.

## Test plan
- Reset release with DIV_INIT defaults, run=1 -> tick[0] at cycles 25_000, 50_000; tick[1] at 50_000, 100_000; sq[1] period 100_000 cycles.
- Write cfg_ch=0, cfg_div=10 at cycle 100 -> cfg_pend[0]=1 until the 25_000 wrap; subsequent ticks every 10 cycles; ch1 unaffected.
- Write cfg_div=0 and a separate write with cfg_ch=5 -> cfg_err pulses once each; div, cfg_pend unchanged.
- div=4, run dropped for 7 cycles mid-period -> tick low throughout; next tick delayed by exactly 7 cycles.
- Both channels div=4 and 6 with pending writes 3 and 3, then sync_clear plus a cfg_wr to ch1 with value 5 -> cnt/sq zeroed, ch0 div=3, ch1 div=5, cfg_pend=0; first ticks 3 and 5 cycles later.
- div=1 -> tick constant 1 while run=1, sq toggles every cycle; rst_n asserted mid-run -> tick, sq, cfg_pend all 0 asynchronously.
